// File: rtl/rf_frame_pkg.sv
// Shared definitions for the RF frame transmitter.
//   state_t           : framer state encoding
//   CRC8_POLY/INIT    : CRC-8 polynomial and initial value (no reflection, no final XOR)
//   DEFAULT_SYNC_WORD : sync word sent MSB first after the preamble
//   crc8_step()       : one bit-serial CRC-8 update, MSB-first data
package rf_frame_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    SYNC     = 3'd2,
    LENGTH   = 3'd3,
    PAYLOAD  = 3'd4,
    CRC      = 3'd5
  } state_t;

  localparam logic [7:0]  CRC8_POLY         = 8'h07;
  localparam logic [7:0]  CRC8_INIT         = 8'h00;
  localparam logic [15:0] DEFAULT_SYNC_WORD = 16'h2DD4;

  // Feedback is the outgoing CRC MSB xor the data bit; the polynomial is
  // folded in whenever that feedback is set.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc_in, input logic bit_in);
    logic fb;
    fb = crc_in[7] ^ bit_in;
    return {crc_in[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/rf_frame_tx_crc8.sv
// Bit-serial CRC-8 accumulator.
//   clk2x, rst_n : clock and asynchronous active-low reset
//   clear        : return the CRC to its initial value (dominates bit_en)
//   bit_en       : fold bit_in into the CRC on this edge
//   bit_in       : data bit, MSB-first order
//   crc          : current CRC value
module crc8_serial
  import rf_frame_pkg::*;
(
  input  logic       clk2x,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       bit_en,
  input  logic       bit_in,
  output logic [7:0] crc
);

  logic [7:0] crc_r;

  // CRC register: one update per enabled edge, clear has priority
  always_ff @(posedge clk2x or negedge rst_n) begin
    if (!rst_n) begin
      crc_r <= CRC8_INIT;
    end else if (clear) begin
      crc_r <= CRC8_INIT;
    end else if (bit_en) begin
      crc_r <= crc8_step(crc_r, bit_in);
    end
  end

  assign crc = crc_r;

endmodule

// File: rtl/rf_frame_tx.sv
// Frame serializer feeding the RF line encoders: preamble, sync word,
// length byte, payload, CRC-8, one bit per two clk2x cycles, MSB first.
//   clk2x, rst_n      : encoder clock (2x bit rate), async active-low reset
//   start, len        : frame request and payload length, sampled in IDLE
//   tx_data, tx_valid,
//   tx_ready          : payload byte source handshake
//   din, enable       : serial bit and frame-active to the encoders
//   busy              : frame in progress
//   done, underrun    : one-cycle completion / abort pulses
module rf_frame_tx
  import rf_frame_pkg::*;
#(
  parameter int unsigned PREAMBLE_BITS = 16,
  parameter logic [15:0] SYNC_WORD     = DEFAULT_SYNC_WORD
) (
  input  logic       clk2x,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] len,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       din,
  output logic       enable,
  output logic       busy,
  output logic       done,
  output logic       underrun
);

  localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_BITS - 1);

  state_t      state_r;
  logic        phase_r;
  logic [7:0]  bit_cnt_r;     // bits still to send in the current field after this one
  logic [15:0] sh_r;          // bits of the current field not yet on din
  logic [7:0]  len_r;
  logic [7:0]  fetched_r;
  logic [7:0]  bytes_left_r;  // payload bytes still to load after the current one
  logic [7:0]  hold_r;
  logic        hold_full_r;
  logic        din_r;
  logic        enable_r;
  logic        busy_r;
  logic        done_r;
  logic        underrun_r;

  logic        advance_s;
  logic        accept_s;
  logic        crc_clear_s;
  logic        crc_en_s;
  logic [7:0]  crc_s;
  logic [7:0]  crc_final_s;

  // A bit period ends on the edge where phase goes 1->0.
  assign advance_s   = busy_r & phase_r;
  assign tx_ready    = busy_r & ~hold_full_r & (fetched_r < len_r);
  assign accept_s    = tx_valid & tx_ready;
  assign crc_clear_s = (state_r == IDLE);
  assign crc_en_s    = advance_s & ((state_r == LENGTH) | (state_r == PAYLOAD));
  // The last payload/length bit is folded in on the same edge that enters CRC,
  // so the value sent must include it.
  assign crc_final_s = crc8_step(crc_s, din_r);

  crc8_serial u_crc (
    .clk2x  (clk2x),
    .rst_n  (rst_n),
    .clear  (crc_clear_s),
    .bit_en (crc_en_s),
    .bit_in (din_r),
    .crc    (crc_s)
  );

  // Framer FSM with registered encoder outputs and byte holding register
  always_ff @(posedge clk2x or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      phase_r      <= 1'b0;
      bit_cnt_r    <= 8'd0;
      sh_r         <= 16'h0000;
      len_r        <= 8'd0;
      fetched_r    <= 8'd0;
      bytes_left_r <= 8'd0;
      hold_r       <= 8'h00;
      hold_full_r  <= 1'b0;
      din_r        <= 1'b0;
      enable_r     <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      underrun_r   <= 1'b0;
    end else begin
      done_r     <= 1'b0;
      underrun_r <= 1'b0;

      if (accept_s) begin
        hold_r      <= tx_data;
        hold_full_r <= 1'b1;
        fetched_r   <= fetched_r + 8'd1;
      end

      if (busy_r) begin
        phase_r <= ~phase_r;
      end

      case (state_r)
        IDLE: begin
          if (start) begin
            state_r     <= PREAMBLE;
            busy_r      <= 1'b1;
            enable_r    <= 1'b1;
            din_r       <= 1'b1;
            phase_r     <= 1'b0;
            bit_cnt_r   <= PRE_LAST;
            len_r       <= len;
            fetched_r   <= 8'd0;
            hold_full_r <= 1'b0;
          end
        end

        PREAMBLE: begin
          if (advance_s) begin
            if (bit_cnt_r != 8'd0) begin
              bit_cnt_r <= bit_cnt_r - 8'd1;
              din_r     <= ~din_r;
            end else begin
              state_r   <= SYNC;
              bit_cnt_r <= 8'd15;
              din_r     <= SYNC_WORD[15];
              sh_r      <= {SYNC_WORD[14:0], 1'b0};
            end
          end
        end

        SYNC: begin
          if (advance_s) begin
            if (bit_cnt_r != 8'd0) begin
              bit_cnt_r <= bit_cnt_r - 8'd1;
              din_r     <= sh_r[15];
              sh_r      <= {sh_r[14:0], 1'b0};
            end else begin
              state_r   <= LENGTH;
              bit_cnt_r <= 8'd7;
              din_r     <= len_r[7];
              sh_r      <= {len_r[6:0], 9'h000};
            end
          end
        end

        LENGTH, PAYLOAD: begin
          if (advance_s) begin
            if (bit_cnt_r != 8'd0) begin
              bit_cnt_r <= bit_cnt_r - 8'd1;
              din_r     <= sh_r[15];
              sh_r      <= {sh_r[14:0], 1'b0};
            end else if ((state_r == LENGTH) ? (len_r == 8'd0) : (bytes_left_r == 8'd0)) begin
              state_r   <= CRC;
              bit_cnt_r <= 8'd7;
              din_r     <= crc_final_s[7];
              sh_r      <= {crc_final_s[6:0], 9'h000};
            end else if (hold_full_r) begin
              state_r      <= PAYLOAD;
              bit_cnt_r    <= 8'd7;
              din_r        <= hold_r[7];
              sh_r         <= {hold_r[6:0], 9'h000};
              hold_full_r  <= 1'b0;
              bytes_left_r <= (state_r == LENGTH) ? (len_r - 8'd1) : (bytes_left_r - 8'd1);
            end else begin
              // Source failed to deliver in time: abort the frame.
              state_r     <= IDLE;
              busy_r      <= 1'b0;
              enable_r    <= 1'b0;
              din_r       <= 1'b0;
              underrun_r  <= 1'b1;
              fetched_r   <= 8'd0;
              hold_full_r <= 1'b0;
            end
          end
        end

        CRC: begin
          if (advance_s) begin
            if (bit_cnt_r != 8'd0) begin
              bit_cnt_r <= bit_cnt_r - 8'd1;
              din_r     <= sh_r[15];
              sh_r      <= {sh_r[14:0], 1'b0};
            end else begin
              state_r     <= IDLE;
              busy_r      <= 1'b0;
              enable_r    <= 1'b0;
              din_r       <= 1'b0;
              done_r      <= 1'b1;
              fetched_r   <= 8'd0;
              hold_full_r <= 1'b0;
            end
          end
        end

        default: begin
          state_r  <= IDLE;
          busy_r   <= 1'b0;
          enable_r <= 1'b0;
          din_r    <= 1'b0;
          phase_r  <= 1'b0;
        end
      endcase
    end
  end

  assign din      = din_r;
  assign enable   = enable_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign underrun = underrun_r;

endmodule

// File: doc/rf_frame_tx.md
Name: rf_frame_tx

Overview:
- Upstream framer for the RF line encoders: accepts a byte stream plus a length and serializes one frame: preamble, sync word, length byte, payload, CRC-8.
- Drives the encoders' `din`/`enable` pair at one bit per two `clk2x` cycles, so the encoders see a stable bit across a full bit period.
- Sits between the packet source (valid/ready byte interface) and the Manchester/Miller/FM encoders, which share `clk2x`.

Parameters:
- PREAMBLE_BITS, 16, number of preamble bits; pattern 1,0,1,0,… starting with 1; legal range 2..255.
- SYNC_WORD, 16'h2DD4, 16-bit sync word sent MSB first.

Ports:
- clk2x  in  1  encoder clock, twice the bit rate
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request a frame; sampled only in IDLE
- len  in  8  payload byte count; latched with start
- tx_data  in  8  payload byte
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  byte accepted when tx_valid && tx_ready
- din  out  1  serial bit to encoders
- enable  out  1  frame active, to encoders
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse, frame completed normally
- underrun  out  1  one-cycle pulse, frame aborted because a payload byte was missing

Behaviour:
- Reset:
  - din, enable, busy, done, underrun and tx_ready are all 0.
  - State is IDLE, phase=0, holding register empty.
- Clock and reset: one clock, `clk2x`. Reset `rst_n` is asynchronous and active-low.
- Bit timing:
  - A phase flop toggles every cycle while busy.
  - din changes only on the edge where phase goes 1->0, or on the launch edge. Each bit is therefore held exactly 2 cycles.
- Launch:
  - If start=1 in IDLE at cycle N, then from N+1: enable=1, busy=1, din = first preamble bit, len latched.
  - start while busy is ignored.
- States and transitions (all data MSB first):
  - IDLE -> PREAMBLE: on start.
  - PREAMBLE -> SYNC: after PREAMBLE_BITS bits.
  - SYNC -> LENGTH: after 16 bits.
  - LENGTH: sends the latched len byte; then goes to PAYLOAD, or straight to CRC if len=0.
  - PAYLOAD: sends 8*len bits; then goes to CRC.
  - CRC -> IDLE: after 8 bits.
- Frame length: PREAMBLE_BITS + 32 + 8*len bit periods. enable is high for exactly twice that many cycles.
- End of frame:
  - On the cycle after the last CRC bit period, enable=0, busy=0, din=0, and done=1 for one cycle.
  - A new start is accepted on that same cycle.
- Byte fetch:
  - One-byte holding register.
  - tx_ready = busy && holding empty && bytes_fetched < len_latched.
  - Fetch begins on the first busy cycle, so source latency is hidden behind the preamble.
  - At each payload byte boundary (the phase 1->0 edge), the shift register loads from the holding register, which then becomes empty.
- Underrun:
  - If the holding register is empty when a payload byte must load, the frame aborts.
  - Next cycle: enable=0, busy=0, din=0, underrun=1 for one cycle, state IDLE; the partially fetched count is discarded.
  - No done pulse is produced.
- CRC:
  - CRC-8, poly 0x07, init 0x00, no reflection, no final XOR.
  - Updated bit-serially over the length and payload bits, once per bit period as each bit is sent.
  - Preamble and sync are excluded.
  - The CRC value is frozen and shifted out MSB first in the CRC state.
- Counters:
  - Bit counter: 8 bits, reloaded at each state entry.
  - Byte counter: 8 bits. len=255 must not wrap early.
- Reset mid-frame: immediate return to reset values. No done or underrun pulse.

Decomposition:
- Package rf_frame_pkg:
  - State enum (IDLE, PREAMBLE, SYNC, LENGTH, PAYLOAD, CRC).
  - CRC8_POLY = 8'h07, CRC8_INIT = 8'h00.
  - Default SYNC_WORD.
- Sub-module crc8_serial:
  - Ports: clk2x, rst_n, clear, bit_en, bit_in, crc[7:0].
  - One update per asserted bit_en.

Test Plan:
- Reset, then start with len=1 and tx_data=0x00 supplied immediately -> enable high for 2*(16+32+8)=112 cycles.
  - din sequence: 1010…(16), 0x2DD4, 0x01, 0x00, CRC 0x15.
  - done pulses on cycle 113 after start.
- len=0 -> no tx_ready assertion; frame = preamble, sync, 0x00, CRC 0x00; enable high 96 cycles; done pulses.
- len=3, bytes 0xA5, 0x5A, 0xFF with tx_valid delayed 20 cycles -> frame completes and the payload bits are exact.
  - CRC matches the model over 0x03 A5 5A FF.
  - Every din transition lands on a phase 1->0 edge.
- len=2, source supplies only one byte -> underrun pulses one cycle after the second payload byte boundary; enable=0 and busy=0; no done.
- start asserted mid-frame, and start asserted on the done cycle -> the mid-frame start is ignored; the done-cycle start launches a new frame with enable staying low for exactly one cycle between frames.
- rst_n asserted low asynchronously during PAYLOAD -> all outputs 0 immediately without a clock edge; after release, a new start produces a correct frame.
